// File: rtl/mux_arb_nto1.sv
// N-to-1 valid/ready channel multiplexer with one registered output stage.
// MODE 0 routes the explicitly selected channel; MODE 1 arbitrates round-robin among valid channels.

module mux_arb_nto1_chk #(
   parameter int CHANNELS = 4,
   parameter int MODE     = 0
) (
   input logic                clk,
   input logic                rst,
   input logic [CHANNELS-1:0] in_ready
);

   mode_legal:   assert property (@(posedge clk) (MODE == 0) || (MODE == 1));
   ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

endmodule

module mux_arb_nto1 #(
   parameter int WIDTH    = 5,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int MODE     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      flush,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SEL_W-1:0]    ptr_r;
   logic [CHANNELS-1:0] grant_s;
   logic [SEL_W-1:0]    grant_idx_s;
   logic [WIDTH-1:0]    cap_data_s;
   logic                can_accept_s;
   logic                xfer_s;
   int                  ptr_int_s;

   assign ptr_int_s = int'(ptr_r);

   // Grant: decoded select, or the first valid channel found scanning upward from the pointer
   always_comb begin
      logic hit_s;
      logic found_s;
      grant_s     = '0;
      grant_idx_s = '0;
      hit_s       = 1'b0;
      found_s     = 1'b0;
      if (MODE == 1) begin
         for (int k = 1; k <= CHANNELS; k++) begin
            for (int i = 0; i < CHANNELS; i++) begin
               hit_s       = !found_s && in_valid[i] && (i == (ptr_int_s + k) % CHANNELS);
               grant_s[i]  = grant_s[i] | hit_s;
               grant_idx_s = hit_s ? SEL_W'(i) : grant_idx_s;
               found_s     = found_s | hit_s;
            end
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            hit_s       = (int'(sel) == i);
            grant_s[i]  = hit_s;
            grant_idx_s = hit_s ? SEL_W'(i) : grant_idx_s;
         end
      end
   end

   // Data mux: grant is one-hot or zero, so an AND-OR tree suffices
   always_comb begin
      cap_data_s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cap_data_s = cap_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      end
   end

   assign can_accept_s = !out_valid || out_ready;
   assign in_ready     = grant_s & {CHANNELS{can_accept_s && !flush}};
   assign xfer_s       = |(in_valid & in_ready);

   // Output register and arbitration pointer; flush wins over both drain and refill
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr_r     <= SEL_W'(CHANNELS - 1);
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer_s) begin
         out_valid <= 1'b1;
         out_data  <= cap_data_s;
         out_chan  <= grant_idx_s;
         if (MODE == 1) begin
            ptr_r <= grant_idx_s;
         end else begin
            ptr_r <= ptr_r;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

   mux_arb_nto1_chk #(
      .CHANNELS (CHANNELS),
      .MODE     (MODE)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .in_ready (in_ready)
   );

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: a select-mode instance (SEL_W=3, so out-of-range selects are reachable)
// and a round-robin instance, both compared every cycle against a behavioural model.

module tb_mux_arb_nto1;

   logic        clk;
   logic        rst;
   logic [19:0] idata  [2];
   logic [3:0]  ivalid [2];
   logic        flush  [2];
   logic        oready [2];
   logic [2:0]  sel0;
   logic [1:0]  sel1;

   logic [3:0]  iready0, iready1;
   logic [4:0]  odata0, odata1;
   logic [2:0]  ochan0;
   logic [1:0]  ochan1;
   logic        ovalid0, ovalid1;

   // model state: output register per instance, arbitration pointer of the round-robin one
   logic        mv [2];
   logic [4:0]  md [2];
   int          mc [2];
   int          mptr;

   int n_checks = 0;
   int n_fail   = 0;
   int fair_exp   [6] = '{0, 1, 2, 3, 0, 1};
   int sparse_exp [4] = '{3, 1, 3, 1};

   mux_arb_nto1 #(.WIDTH(5), .CHANNELS(4), .SEL_W(3), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .in_data(idata[0]), .in_valid(ivalid[0]), .in_ready(iready0),
      .sel(sel0), .flush(flush[0]), .out_data(odata0), .out_chan(ochan0),
      .out_valid(ovalid0), .out_ready(oready[0]));

   mux_arb_nto1 #(.WIDTH(5), .CHANNELS(4), .SEL_W(2), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .in_data(idata[1]), .in_valid(ivalid[1]), .in_ready(iready1),
      .sel(sel1), .flush(flush[1]), .out_data(odata1), .out_chan(ochan1),
      .out_valid(ovalid1), .out_ready(oready[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // channel that the rules grant right now, -1 for none
   function automatic int pick(int d);
      int order[$];
      if (d == 0) return (sel0 < 3'd4) ? int'(sel0) : -1;
      for (int k = 1; k <= 4; k++) order.push_back((mptr + k) % 4);
      foreach (order[j]) if (ivalid[1][order[j]]) return order[j];
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready(int d);
      int g;
      g = pick(d);
      if (g < 0 || flush[d] || (mv[d] && !oready[d])) return 4'b0000;
      return 4'(1 << g);
   endfunction

   function automatic bit accepts(int d);
      int g;
      logic [3:0] r;
      g = pick(d);
      r = exp_ready(d);
      return (g >= 0) && r[g] && ivalid[d][g];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            mv[d] <= 1'b0;
            md[d] <= 5'd0;
            mc[d] <= 0;
         end
         mptr <= 3;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (flush[d]) mv[d] <= 1'b0;
            else if (accepts(d)) begin
               md[d] <= idata[d][pick(d)*5 +: 5];
               mc[d] <= pick(d);
               mv[d] <= 1'b1;
               if (d == 1) mptr <= pick(d);
            end else if (oready[d]) mv[d] <= 1'b0;
         end
      end
   end

   task automatic cmp(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic compare_all();
      cmp("u0 in_ready",  int'(iready0), int'(exp_ready(0)));
      cmp("u0 out_valid", int'(ovalid0), int'(mv[0]));
      cmp("u0 out_data",  int'(odata0),  int'(md[0]));
      cmp("u0 out_chan",  int'(ochan0),  mc[0]);
      cmp("u1 in_ready",  int'(iready1), int'(exp_ready(1)));
      cmp("u1 out_valid", int'(ovalid1), int'(mv[1]));
      cmp("u1 out_data",  int'(odata1),  int'(md[1]));
      cmp("u1 out_chan",  int'(ochan1),  mc[1]);
   endtask

   // called at a falling edge after inputs are set: check, then run one clock
   task automatic step();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   initial begin
      rst  = 1'b1;
      sel0 = 3'd0;
      sel1 = 2'd0;
      for (int d = 0; d < 2; d++) begin
         idata[d]  = 20'h0;
         ivalid[d] = 4'b0000;
         flush[d]  = 1'b0;
         oready[d] = 1'b0;
      end
      @(negedge clk);
      step();
      cmp("reset u0 out_valid", int'(ovalid0), 0);
      cmp("reset u0 out_data",  int'(odata0), 0);
      cmp("reset u1 out_valid", int'(ovalid1), 0);
      cmp("reset u1 out_chan",  int'(ochan1), 0);
      rst = 1'b0;
      step();

      // explicit select of channel 2 while channel 0 is also valid
      sel0      = 3'd2;
      idata[0]  = 20'h0;
      idata[0][14:10] = 5'h15;
      idata[0][4:0]   = 5'h0A;
      ivalid[0] = 4'b0101;
      oready[0] = 1'b1;
      #1 cmp("sel2 in_ready", int'(iready0), 4'b0100);
      step();
      cmp("sel2 out_data",  int'(odata0), 5'h15);
      cmp("sel2 out_chan",  int'(ochan0), 2);
      cmp("sel2 out_valid", int'(ovalid0), 1);

      // backpressure: held beat stays put while new channel data wiggles
      oready[0] = 1'b0;
      idata[0][14:10] = 5'h0B;
      for (int n = 0; n < 3; n++) begin
         step();
         cmp("stall in_ready", int'(iready0), 0);
         cmp("stall out_data", int'(odata0), 5'h15);
      end
      oready[0] = 1'b1;
      step();
      cmp("refill out_data",  int'(odata0), 5'h0B);
      cmp("refill out_valid", int'(ovalid0), 1);
      ivalid[0] = 4'b0000;

      // round-robin fairness with every channel requesting
      idata[1]  = 20'hA5C3E;
      ivalid[1] = 4'b1111;
      oready[1] = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         cmp("fair out_chan", int'(ochan1), fair_exp[n]);
      end

      // sparse requests, then a single requester
      ivalid[1] = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         step();
         cmp("sparse out_chan", int'(ochan1), sparse_exp[n]);
      end
      ivalid[1] = 4'b0010;
      for (int n = 0; n < 3; n++) begin
         step();
         cmp("single out_chan", int'(ochan1), 1);
      end

      // out-of-range select grants nothing
      sel0      = 3'd5;
      ivalid[0] = 4'b1111;
      for (int n = 0; n < 2; n++) begin
         step();
         cmp("sel5 in_ready",  int'(iready0), 0);
         cmp("sel5 out_valid", int'(ovalid0), 0);
      end

      // flush drops the beat, accepts nothing, keeps pointer at 1 so ch0 wins over ch1 next
      ivalid[1] = 4'b0001;
      flush[1]  = 1'b1;
      step();
      cmp("flush out_valid", int'(ovalid1), 0);
      cmp("flush in_ready",  int'(iready1), 0);
      flush[1]  = 1'b0;
      ivalid[1] = 4'b0011;
      step();
      cmp("post-flush out_chan",  int'(ochan1), 0);
      cmp("post-flush out_valid", int'(ovalid1), 1);

      // asynchronous reset in mid-cycle while holding 5'h1F
      sel0      = 3'd1;
      idata[0]  = 20'h0;
      idata[0][9:5] = 5'h1F;
      ivalid[0] = 4'b0010;
      oready[0] = 1'b0;
      step();
      cmp("pre-reset out_data", int'(odata0), 5'h1F);
      #2 rst = 1'b1;
      #1;
      cmp("async reset out_valid", int'(ovalid0), 0);
      cmp("async reset out_data",  int'(odata0), 0);
      cmp("async reset out_chan",  int'(ochan0), 0);
      @(negedge clk);
      rst       = 1'b0;
      ivalid[1] = 4'b1111;
      oready[1] = 1'b1;
      step();
      cmp("after reset first grant", int'(ochan1), 0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 2; d++) begin
            idata[d]  = 20'($urandom);
            ivalid[d] = 4'($urandom);
            oready[d] = ($urandom_range(0, 3) != 0);
            flush[d]  = ($urandom_range(0, 11) == 0);
         end
         sel0 = 3'($urandom_range(0, 7));
         sel1 = 2'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
Parametrised N-to-1 channel multiplexer with a registered output stage and a valid/ready handshake on every channel. It generalises the datapath 2:1 select muxes in width, channel count and mode. MODE 0 routes the channel picked by an explicit select. MODE 1 picks among valid channels by round-robin arbitration. It sits between pipeline stages in the CPU (write-back source selection, shared-resource request merging) and supplies one register stage of buffering with backpressure.

Parameters:
WIDTH, 5, data width per channel in bits.
CHANNELS, 4, number of input channels; legal range 2..2**SEL_W.
SEL_W, 2, width of sel and out_chan.
MODE, 0, 0 = explicit select, 1 = round-robin arbitration (sel ignored).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  input  CHANNELS  per-channel valid.
in_ready  output  CHANNELS  per-channel ready (combinational).
sel  input  SEL_W  channel select, MODE 0 only.
flush  input  1  synchronous discard of the output register.
out_data  output  WIDTH  registered data.
out_chan  output  SEL_W  registered index of the source channel.
out_valid  output  1  output register holds a beat.
out_ready  input  1  downstream accepts the beat.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: out_valid=0, out_data=0, out_chan=0, round-robin pointer=CHANNELS-1, so channel 0 has first priority.
- Reset mid-transfer: an in-flight beat is dropped with no recovery.
- Storage: one output register, the only storage.
  - can_accept = !out_valid | out_ready.
  - Input-to-output latency is 1 cycle.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Grant selection (combinational, one-hot or none):
  - MODE 0: grant = sel when sel < CHANNELS. When sel >= CHANNELS there is no grant.
  - MODE 1: search from pointer+1 upward, wrapping at CHANNELS-1 to 0. The first channel with in_valid=1 is granted. No valid channel means no grant.
- Ready: in_ready[i] = grant[i] & can_accept & !flush. At most one in_ready bit is high in any cycle.
- Transfer: a transfer on channel i happens when in_valid[i] & in_ready[i]. On that edge:
  - out_data <= channel i data;
  - out_chan <= i;
  - out_valid <= 1.
- Drain without refill: when out_valid & out_ready and there is no input transfer, out_valid <= 0. out_data and out_chan keep their last values.
- Stall: when out_valid & !out_ready, out_data and out_chan stay stable and all in_ready are 0.
- Simultaneous drain and refill in one cycle is legal and produces back-to-back beats.
- Round-robin pointer:
  - Updated to i only on a transfer from channel i.
  - Unchanged on stall, flush, or a no-grant cycle.
  - MODE 0 leaves the pointer unused (held at reset value).
- Flush:
  - Next edge: out_valid <= 0.
  - No input is accepted during a flush cycle.
  - Flush has priority over out_ready and over an input transfer.
  - The pointer is unchanged.
- Channel data changes while in_valid=1 and in_ready=0 are allowed. Only the value present on the accept edge is captured.
- MODE values other than 0 or 1 are illegal. The implementation asserts on them in simulation.

Test Plan:
1. Reset: assert rst asynchronously while out_valid=1 with out_data=5'h1F -> out_valid, out_data and out_chan go to 0 immediately, before the next clk edge. After release, in MODE 1, channel 0 is granted first.
2. MODE 0 select: sel=2, ch2 data=5'h15 valid, ch0 valid, out_ready=1 -> in_ready=4'b0100. One cycle later out_data=5'h15, out_chan=2, out_valid=1. ch0 is never accepted.
3. Backpressure: beat held, out_ready=0 for 3 cycles -> out_data is stable and in_ready=0 every cycle. Raise out_ready with ch2 valid -> drain and new accept in the same cycle, and out_valid stays 1.
4. MODE 1 fairness: all 4 channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
5. MODE 1 sparse: only ch1 and ch3 valid -> out_chan alternates 1,3,1,3. Then ch3 drops -> out_chan is 1 every cycle.
6. Boundaries:
   - CHANNELS=4, SEL_W=3, sel=5 -> in_ready=0 and out_valid stays 0.
   - flush=1 while out_valid=1 and ch0 valid -> next cycle out_valid=0, no accept, pointer unchanged.
